// File: rtl/ud_count_arbiter.sv
// Round-robin shared up/down counter: two requesters each ask for a burst
// of steps in a chosen direction; one step is applied per clock.
// Ports: clk, reset (sync, active-low); req/dir/steps per requester;
//   gnt0/gnt1 grant, done0/done1 burst-complete pulse, busy, q counter,
//   wrap pulse when a step crossed the counter boundary.
module ud_count_arbiter #(
  parameter int WIDTH = 2,
  parameter int STEPW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             dir0,
  input  logic [STEPW-1:0] steps0,
  input  logic             req1,
  input  logic             dir1,
  input  logic [STEPW-1:0] steps1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_q, w_q_nx;
  logic [STEPW-1:0]   r_rem, w_rem_nx;
  logic               r_dir, w_dir_nx;
  logic               r_win, w_win_nx;
  logic               r_rr_last, w_rr_nx;
  logic               r_gnt0, w_gnt0_nx;
  logic               r_gnt1, w_gnt1_nx;
  logic               r_done0, w_done0_nx;
  logic               r_done1, w_done1_nx;
  logic               r_wrap, w_wrap_nx;

  // Contention goes to whoever did not win last time.
  logic               w_pick;
  logic [STEPW-1:0]   w_steps;
  logic               w_dir;

  assign w_pick  = (req0 & req1) ? ~r_rr_last : req1;
  assign w_steps = w_pick ? steps1 : steps0;
  assign w_dir   = w_pick ? dir1 : dir0;

  always_comb begin
    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_rem_nx   = r_rem;
    w_dir_nx   = r_dir;
    w_win_nx   = r_win;
    w_rr_nx    = r_rr_last;
    w_gnt0_nx  = r_gnt0;
    w_gnt1_nx  = r_gnt1;
    w_done0_nx = r_done0;
    w_done1_nx = r_done1;
    w_wrap_nx  = r_wrap;
    unique case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_win_nx  = w_pick;
          w_rr_nx   = w_pick;
          w_dir_nx  = w_dir;
          w_rem_nx  = w_steps;
          w_gnt0_nx = ~w_pick;
          w_gnt1_nx = w_pick;
          if (w_steps == '0) begin
            w_state_nx = S_DONE;
            w_done0_nx = ~w_pick;
            w_done1_nx = w_pick;
          end else begin
            w_state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_q_nx    = r_dir ? r_q - 1'b1 : r_q + 1'b1;
        w_wrap_nx = r_dir ? (r_q == '0) : (r_q == '1);
        w_rem_nx  = r_rem - 1'b1;
        if (r_rem == STEPW'(1)) begin
          w_state_nx = S_DONE;
          w_done0_nx = ~r_win;
          w_done1_nx = r_win;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_gnt0_nx  = 1'b0;
        w_gnt1_nx  = 1'b0;
        w_done0_nx = 1'b0;
        w_done1_nx = 1'b0;
        w_wrap_nx  = 1'b0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_rem     <= '0;
      r_dir     <= 1'b0;
      r_win     <= 1'b0;
      r_rr_last <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_q       <= w_q_nx;
      r_rem     <= w_rem_nx;
      r_dir     <= w_dir_nx;
      r_win     <= w_win_nx;
      r_rr_last <= w_rr_nx;
      r_gnt0    <= w_gnt0_nx;
      r_gnt1    <= w_gnt1_nx;
      r_done0   <= w_done0_nx;
      r_done1   <= w_done1_nx;
      r_wrap    <= w_wrap_nx;
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign busy  = (r_state != S_IDLE);
  assign q     = r_q;
  assign wrap  = r_wrap;

endmodule
